// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// Module : rv_pkg
// Brief  : Shared RV32I pipeline constants for the writeback/register-file slice.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] RESULTSRC_ALU = 2'b00;
    localparam logic [1:0] RESULTSRC_MEM = 2'b01;
    localparam logic [1:0] RESULTSRC_PC4 = 2'b10;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // The reserved code 2'b11 deliberately falls back to the ALU result.
    function automatic logic [XLEN-1:0] select_result(
        input logic [1:0]      src,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] pc4
    );
        logic [XLEN-1:0] v;
        case (src)
            RESULTSRC_MEM: v = mem;
            RESULTSRC_PC4: v = pc4;
            default:       v = alu;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//------------------------------------------------------------------------------
// Module : regfile_2r1w
// Brief  : Two-read/one-write integer register array, x0 hardwired to zero,
//          asynchronous clear and optional same-cycle write-to-read bypass.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w
    import rv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [REG_AW-1:0]   i_waddr,
    input  logic [XLEN_P-1:0]   i_wdata,
    input  logic [REG_AW-1:0]   i_raddr1,
    input  logic [REG_AW-1:0]   i_raddr2,
    output logic [XLEN_P-1:0]   o_rdata1,
    output logic [XLEN_P-1:0]   o_rdata2,
    output logic                o_commit
);

    logic [XLEN_P-1:0] r_regs [NREGS_P];
    logic              w_commit;
    logic              w_hit1;
    logic              w_hit2;

    assign w_commit = i_we && (i_waddr != REG_ZERO);
    assign o_commit = w_commit;

    // Entry 0 is cleared on reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS_P; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign w_hit1 = BYPASS && w_commit && (i_waddr == i_raddr1);
    assign w_hit2 = BYPASS && w_commit && (i_waddr == i_raddr2);

    // Reads are forced to zero while reset is held so no bypassed value leaks out.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (rst_n && (i_raddr1 != REG_ZERO)) begin
            o_rdata1 = w_hit1 ? i_wdata : r_regs[i_raddr1];
        end
        if (rst_n && (i_raddr2 != REG_ZERO)) begin
            o_rdata2 = w_hit2 ? i_wdata : r_regs[i_raddr2];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
//------------------------------------------------------------------------------
// Module : wb_regfile
// Brief  : RV32I writeback stage: result select, register-file commit with
//          W->D bypass, and a retired-write counter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_regfile
    import rv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter bit BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWrite_W,
    input  logic [1:0]         ResultSrc_W,
    input  logic [XLEN_P-1:0]  ALUResult_W,
    input  logic [XLEN_P-1:0]  ReadData_W,
    input  logic [XLEN_P-1:0]  PCPlus4_W,
    input  logic [31:0]        Rd_W,
    input  logic [4:0]         Rs1_D,
    input  logic [4:0]         Rs2_D,
    output logic [XLEN_P-1:0]  RD1_D,
    output logic [XLEN_P-1:0]  RD2_D,
    output logic [XLEN_P-1:0]  Result_W,
    output logic [31:0]        wb_count
);

    logic [XLEN_P-1:0] w_result;
    logic              w_commit;
    logic [31:0]       r_wb_count;
    logic              w_unused_rd;

    // Upper destination bits carry no meaning in RV32I.
    assign w_unused_rd = ^Rd_W[31:REG_AW];

    assign w_result = select_result(ResultSrc_W, ALUResult_W, ReadData_W, PCPlus4_W);
    assign Result_W = w_result;

    regfile_2r1w #(
        .XLEN_P  (XLEN_P),
        .NREGS_P (NREGS_P),
        .BYPASS  (BYPASS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .i_we     (RegWrite_W),
        .i_waddr  (Rd_W[REG_AW-1:0]),
        .i_wdata  (w_result),
        .i_raddr1 (Rs1_D),
        .i_raddr2 (Rs2_D),
        .o_rdata1 (RD1_D),
        .o_rdata2 (RD2_D),
        .o_commit (w_commit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign wb_count = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
//------------------------------------------------------------------------------
// Module : tb_wb_regfile
// Brief  : Scoreboard bench for wb_regfile (bypassing and non-bypassing builds).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [31:0] ALUResult_W, ReadData_W, PCPlus4_W, Rd_W;
    logic [4:0]  Rs1_D, Rs2_D;
    logic [31:0] RD1_D, RD2_D, Result_W, wb_count;
    logic [31:0] nb_RD1_D, nb_RD2_D, nb_Result_W, nb_wb_count;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W),
        .Rd_W(Rd_W), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .Result_W(Result_W), .wb_count(wb_count)
    );

    wb_regfile #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W),
        .Rd_W(Rd_W), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD1_D(nb_RD1_D), .RD2_D(nb_RD2_D),
        .Result_W(nb_Result_W), .wb_count(nb_wb_count)
    );

    localparam int S_RD1 = 0, S_RD2 = 1, S_RES = 2, S_WB = 3, S_NRD1 = 4, S_NRD2 = 5, S_NWB = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD1:   return RD1_D;
            S_RD2:   return RD2_D;
            S_RES:   return Result_W;
            S_WB:    return wb_count;
            S_NRD1:  return nb_RD1_D;
            S_NRD2:  return nb_RD2_D;
            default: return nb_wb_count;
        endcase
    endfunction

    exp_t        m_item;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (q.size() != 0) begin
            m_item = q.pop_front();
            m_act  = observe(m_item.sel);
            total++;
            if (m_act !== m_item.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h at %0t", m_item.name, m_act, m_item.exp, $time);
            end
        end
    end

    task automatic push(input string n, input int sel, input logic [31:0] e);
        exp_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = e;
        q.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [31:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        RegWrite_W  = we;
        ResultSrc_W = src;
        ALUResult_W = alu;
        ReadData_W  = mem;
        PCPlus4_W   = pc4;
        Rd_W        = rd;
        Rs1_D       = r1;
        Rs2_D       = r2;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        repeat (2) step();
        reset = 1'b1;

        // Preload x2 so the mid-run reset has something to clear.
        drive(1'b1, 2'b00, 32'hAAAA, 32'h0, 32'h0, 32'd2, 5'd2, 5'd0);
        push("res_pre", S_RES, 32'hAAAA);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd2, 5'd0);
        push("x2_pre", S_RD1, 32'hAAAA);
        push("wb_pre", S_WB, 32'd1);
        step();

        // Reset mid-stream with a pending bypassable write.
        reset = 1'b0;
        drive(1'b1, 2'b01, 32'h11, 32'h77, 32'h33, 32'd2, 5'd2, 5'd2);
        push("rst_rd1", S_RD1, 32'h0);
        push("rst_rd2", S_RD2, 32'h0);
        push("rst_wb", S_WB, 32'h0);
        push("rst_nwb", S_NWB, 32'h0);
        push("rst_res", S_RES, 32'h77);
        step();
        push("rst_edge_wb", S_WB, 32'h0);
        push("rst_edge_rd1", S_RD1, 32'h0);
        step();
        reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'(i), 5'(i));
            push("clr_rd1", S_RD1, 32'h0);
            push("clr_nrd2", S_NRD2, 32'h0);
            step();
        end

        // Result source select.
        drive(1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 32'd5, 5'd0, 5'd0);
        push("src_alu_res", S_RES, 32'h1234);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd5, 5'd0);
        push("src_alu_x5", S_RD1, 32'h1234);
        push("src_alu_wb", S_WB, 32'd1);
        step();
        drive(1'b1, 2'b01, 32'h1, 32'hDEADBEEF, 32'h0, 32'd6, 5'd0, 5'd0);
        push("src_mem_res", S_RES, 32'hDEADBEEF);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd6, 5'd0);
        push("src_mem_x6", S_RD1, 32'hDEADBEEF);
        push("src_mem_wb", S_WB, 32'd2);
        step();
        drive(1'b1, 2'b10, 32'h1, 32'h2, 32'h104, 32'd1, 5'd0, 5'd0);
        push("src_pc4_res", S_RES, 32'h104);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd1, 5'd0);
        push("src_pc4_x1", S_RD1, 32'h104);
        push("src_pc4_wb", S_WB, 32'd3);
        step();
        drive(1'b1, 2'b11, 32'h55, 32'hBAD, 32'hBAD, 32'd8, 5'd0, 5'd0);
        push("src_rsv_res", S_RES, 32'h55);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd8, 5'd5);
        push("src_rsv_x8", S_RD1, 32'h55);
        push("src_rsv_x5", S_RD2, 32'h1234);
        push("src_rsv_wb", S_WB, 32'd4);
        step();

        // x0 protection, including an aliased Rd_W.
        drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0);
        push("x0_nobyp", S_RD1, 32'h0);
        push("x0_res", S_RES, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h20, 5'd0, 5'd0);
        push("x0_rd1", S_RD1, 32'h0);
        push("x0_rd2", S_RD2, 32'h0);
        push("x0_wb", S_WB, 32'd4);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0);
        push("x0_alias_rd1", S_RD1, 32'h0);
        push("x0_alias_wb", S_WB, 32'd4);
        step();

        // Bypass versus no-bypass.
        drive(1'b1, 2'b00, 32'h11, 32'h0, 32'h0, 32'd7, 5'd0, 5'd0);
        step();
        drive(1'b1, 2'b00, 32'h22, 32'h0, 32'h0, 32'd7, 5'd7, 5'd7);
        push("byp_rd1", S_RD1, 32'h22);
        push("byp_rd2", S_RD2, 32'h22);
        push("nbyp_rd1", S_NRD1, 32'h11);
        push("nbyp_rd2", S_NRD2, 32'h11);
        push("byp_wb", S_WB, 32'd5);
        push("nbyp_wb", S_NWB, 32'd5);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd7, 5'd7);
        push("byp_after_rd1", S_RD1, 32'h22);
        push("nbyp_after_rd1", S_NRD1, 32'h22);
        push("nbyp_after_rd2", S_NRD2, 32'h22);
        push("byp_after_wb", S_WB, 32'd6);
        push("nbyp_after_wb", S_NWB, 32'd6);
        step();

        // Disabled write.
        drive(1'b0, 2'b00, 32'h99, 32'h0, 32'h0, 32'd9, 5'd9, 5'd9);
        push("dis_rd1", S_RD1, 32'h0);
        push("dis_rd2", S_RD2, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd9, 5'd0);
        push("dis_after", S_RD1, 32'h0);
        push("dis_wb", S_WB, 32'd6);
        step();

        // Independent ports: one bypassed, one from the array.
        drive(1'b1, 2'b00, 32'hAB, 32'h0, 32'h0, 32'd5, 5'd5, 5'd6);
        push("split_rd1", S_RD1, 32'hAB);
        push("split_rd2", S_RD2, 32'hDEADBEEF);
        step();

        // Counter wrap.
        drive(1'b1, 2'b00, 32'h333, 32'h0, 32'h0, 32'd3, 5'd0, 5'd0);
        push("split_wb", S_WB, 32'd7);
        step();
        drive(1'b1, 2'b00, 32'h333, 32'h0, 32'h0, 32'd3, 5'd0, 5'd0);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        force dut_nb.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        release dut_nb.r_wb_count;
        push("wrap_pre", S_WB, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'd3, 5'd0);
        push("wrap_x3", S_RD1, 32'h333);
        push("wrap_wb", S_WB, 32'h0);
        push("wrap_nwb", S_NWB, 32'h0);
        step();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 2'b00, 32'(i), 32'h0, 32'h0, 32'(i), 5'(i), 5'(i - 1));
            push("burst_byp", S_RD1, 32'(i));
            push("burst_prev", S_RD2, (i == 1) ? 32'h0 : 32'(i - 1));
            step();
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'd0, 5'(i), 5'(i));
            push("burst_rd1", S_RD1, 32'(i));
            push("burst_nrd2", S_NRD2, 32'(i));
            if (i == 1) begin
                push("burst_wb", S_WB, 32'd31);
                push("burst_nwb", S_NWB, 32'd31);
            end
            step();
        end

        step();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
